// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter among NREQ byte sources,
// with optional burst lock so a source can send a multi-byte message.
module uart_tx_arbiter #(
  parameter int NREQ      = 4,
  parameter int DBIT      = 8,
  parameter int IDX_W     = 2,
  parameter int MAX_BURST = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NREQ-1:0]      req,
  input  logic [NREQ-1:0]      req_last,
  input  logic [NREQ*DBIT-1:0] req_data,
  output logic [NREQ-1:0]      req_ack,
  output logic [IDX_W-1:0]     grant_id,
  output logic                 busy,
  output logic                 tx_start,
  output logic [DBIT-1:0]      tx_din,
  input  logic                 tx_done
);

  localparam int CW = $clog2(MAX_BURST + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_WAIT,
    S_ACK,
    S_HOLD
  } state_t;

  state_t           r_state, w_state;
  logic [IDX_W-1:0] r_ptr, w_ptr;
  logic             r_last, w_last;
  logic [CW-1:0]    r_cnt, w_cnt;
  logic [NREQ-1:0]  r_ack, w_ack;
  logic [IDX_W-1:0] r_gid, w_gid;
  logic             r_busy, w_busy;
  logic             r_start, w_start;
  logic [DBIT-1:0]  r_din, w_din;
  logic             w_hit;
  logic [IDX_W-1:0] w_sel;

  function automatic logic [IDX_W-1:0] wrap_add(
    input logic [IDX_W-1:0] a,
    input int               n
  );
    int s;
    s = int'(a) + n;
    if (s >= NREQ) s = s - NREQ;
    return s[IDX_W-1:0];
  endfunction

  // First requester at or above the rotating pointer wins.
  always_comb begin
    w_hit = 1'b0;
    w_sel = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (!w_hit && req[wrap_add(r_ptr, i)]) begin
        w_hit = 1'b1;
        w_sel = wrap_add(r_ptr, i);
      end
    end
  end

  always_comb begin
    w_state = r_state;
    w_ptr   = r_ptr;
    w_last  = r_last;
    w_cnt   = r_cnt;
    w_ack   = '0;
    w_gid   = r_gid;
    w_busy  = r_busy;
    w_start = 1'b0;
    w_din   = r_din;
    unique case (r_state)
      S_IDLE: begin
        if (w_hit) begin
          w_din   = req_data[w_sel*DBIT +: DBIT];
          w_gid   = w_sel;
          w_last  = req_last[w_sel];
          w_busy  = 1'b1;
          w_cnt   = CW'(1);
          w_start = 1'b1;
          w_state = S_START;
        end
      end
      S_START: w_state = S_WAIT;
      S_WAIT: begin
        if (tx_done) begin
          w_ack[r_gid] = 1'b1;
          w_state      = S_ACK;
        end
      end
      S_ACK: begin
        if (r_last || r_cnt == CW'(MAX_BURST)) begin
          w_busy  = 1'b0;
          w_ptr   = wrap_add(r_gid, 1);
          w_state = S_IDLE;
        end else begin
          w_state = S_HOLD;
        end
      end
      S_HOLD: begin
        if (req[r_gid]) begin
          w_din   = req_data[r_gid*DBIT +: DBIT];
          w_last  = req_last[r_gid];
          w_cnt   = r_cnt + CW'(1);
          w_start = 1'b1;
          w_state = S_START;
        end
      end
      default: w_state = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
      r_ptr   <= '0;
      r_last  <= 1'b0;
      r_cnt   <= '0;
      r_ack   <= '0;
      r_gid   <= '0;
      r_busy  <= 1'b0;
      r_start <= 1'b0;
      r_din   <= '0;
    end else begin
      r_state <= w_state;
      r_ptr   <= w_ptr;
      r_last  <= w_last;
      r_cnt   <= w_cnt;
      r_ack   <= w_ack;
      r_gid   <= w_gid;
      r_busy  <= w_busy;
      r_start <= w_start;
      r_din   <= w_din;
    end
  end

  assign req_ack  = r_ack;
  assign grant_id = r_gid;
  assign busy     = r_busy;
  assign tx_start = r_start;
  assign tx_din   = r_din;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Scoreboard bench for uart_tx_arbiter with a modelled tx and
// queue-backed byte sources.
module tb_uart_tx_arbiter;

  localparam int NREQ = 4;
  localparam int DBIT = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [3:0]  req, req_last, req_ack;
  logic [31:0] req_data;
  logic [1:0]  grant_id;
  logic        busy, tx_start, tx_done;
  logic [7:0]  tx_din;
  logic        model_done = 1'b0;
  logic        force_done = 1'b0;

  assign tx_done = model_done | force_done;

  always #5 clk = ~clk;

  uart_tx_arbiter #(
    .NREQ(NREQ), .DBIT(DBIT), .IDX_W(2), .MAX_BURST(16)
  ) dut (
    .clk(clk), .rst(rst), .req(req), .req_last(req_last),
    .req_data(req_data), .req_ack(req_ack), .grant_id(grant_id),
    .busy(busy), .tx_start(tx_start), .tx_din(tx_din),
    .tx_done(tx_done)
  );

  // byte sources: {last, data} per entry
  logic [8:0] mem [NREQ][64];
  int tail [NREQ] = '{default: 0};
  int head [NREQ] = '{default: 0};

  always_comb begin
    req      = '0;
    req_last = '0;
    req_data = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (head[i] != tail[i]) begin
        req[i]             = 1'b1;
        req_last[i]        = mem[i][head[i] % 64][8];
        req_data[i*8 +: 8] = mem[i][head[i] % 64][7:0];
      end
    end
  end

  always @(negedge clk) begin
    for (int i = 0; i < NREQ; i++) begin
      if (!rst) head[i] <= tail[i];
      else if (req_ack[i] && head[i] != tail[i]) head[i] <= head[i] + 1;
    end
  end

  // tx model: frame completes 10 cycles after tx_start
  int cnt = 0;
  always @(posedge clk) begin
    model_done <= 1'b0;
    if (cnt != 0) begin
      cnt <= cnt - 1;
      if (cnt == 1) model_done <= 1'b1;
    end else if (tx_start) begin
      cnt <= 10;
    end
  end

  typedef struct { int id; int data; } st_t;
  typedef struct { int id; bit rel; } ak_t;
  typedef struct { string name; int sel; int exp; } ck_t;
  st_t sq [$];
  ak_t aq [$];
  ck_t cq [$];

  int npass = 0;
  int ntot  = 0;

  function automatic void chk(string nm, int act, int exp);
    ntot++;
    if (act == exp) npass++;
    else $display("FAIL %s: got 0x%0h, required 0x%0h", nm, act, exp);
  endfunction

  function automatic int pending();
    int n;
    n = 0;
    for (int i = 0; i < NREQ; i++) if (head[i] != tail[i]) n++;
    return n;
  endfunction

  bit         din_v = 0;
  logic [7:0] din_lat = '0;
  bit         rel_v = 0;
  bit         rel_exp = 0;

  always @(negedge clk) begin : mon
    ck_t c;
    st_t s;
    ak_t a;
    int  obs;
    while (cq.size() > 0) begin
      c = cq.pop_front();
      case (c.sel)
        0:       obs = int'(busy);
        1:       obs = int'(tx_start);
        2:       obs = int'(tx_din);
        3:       obs = int'(req_ack);
        4:       obs = int'(grant_id);
        default: obs = sq.size() + aq.size() + int'(busy) + pending();
      endcase
      chk(c.name, obs, c.exp);
    end
    if (!rst) begin
      din_v = 0;
      rel_v = 0;
    end else begin
      if (rel_v) begin
        chk("release_busy", int'(busy), int'(!rel_exp));
        rel_v = 0;
      end
      if (tx_done && din_v) begin
        chk("din_stable", int'(tx_din), int'(din_lat));
        din_v = 0;
      end
      if (tx_start) begin
        if (sq.size() == 0) begin
          ntot++;
          $display("FAIL start_unexpected: got id %0d din 0x%0h, required none",
                   grant_id, tx_din);
        end else begin
          s = sq.pop_front();
          chk("start_id", int'(grant_id), s.id);
          chk("start_din", int'(tx_din), s.data);
          din_lat = tx_din;
          din_v   = 1;
        end
      end
      if (req_ack != 4'b0) begin
        if (aq.size() == 0) begin
          ntot++;
          $display("FAIL ack_unexpected: got 0x%0h, required none", req_ack);
        end else begin
          a = aq.pop_front();
          chk("ack", int'(req_ack), 1 << a.id);
          rel_v   = 1;
          rel_exp = a.rel;
        end
      end
    end
  end

  task automatic step(int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic push(int s, int d, bit l);
    logic [7:0] b;
    b = d[7:0];
    mem[s][tail[s] % 64] = {l, b};
    tail[s] = tail[s] + 1;
  endtask

  task automatic xs(int id, int d);
    st_t e;
    e.id = id; e.data = d;
    sq.push_back(e);
  endtask

  task automatic xa(int id, bit rel);
    ak_t e;
    e.id = id; e.rel = rel;
    aq.push_back(e);
  endtask

  task automatic post(string nm, int sel, int exp);
    ck_t e;
    e.name = nm; e.sel = sel; e.exp = exp;
    cq.push_back(e);
  endtask

  task automatic do_reset();
    rst = 1'b0;
    step(2);
    rst = 1'b1;
    step(1);
  endtask

  task automatic wait_drain(int n);
    for (int k = 0; k < n; k++) begin
      if (sq.size() == 0 && aq.size() == 0 && !busy && pending() == 0)
        break;
      step(1);
    end
    post("drain", 5, 0);
    step(1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, required completion");
    $fatal(1);
  end

  initial begin
    step(1);
    post("rst_busy", 0, 0);
    post("rst_start", 1, 0);
    post("rst_ack", 3, 0);
    post("rst_gid", 4, 0);
    post("rst_din", 2, 0);
    step(1);
    rst = 1'b1;
    step(1);

    // single byte, latency and release
    push(0, 'h55, 1);
    xs(0, 'h55); xa(0, 1);
    step(1);
    post("lat_start", 1, 1);
    post("lat_din", 2, 'h55);
    post("lat_busy", 0, 1);
    wait_drain(60);

    // two sources alternate
    do_reset();
    push(1, 'h10, 1); push(1, 'h12, 1);
    push(2, 'h20, 1); push(2, 'h21, 1);
    xs(1, 'h10); xa(1, 1); xs(2, 'h20); xa(2, 1);
    xs(1, 'h12); xa(1, 1); xs(2, 'h21); xa(2, 1);
    wait_drain(120);

    // locked burst from source 3, then source 0
    do_reset();
    push(3, 'hA1, 0); push(3, 'hA2, 0); push(3, 'hA3, 1);
    xs(3, 'hA1); xa(3, 0); xs(3, 'hA2); xa(3, 0);
    xs(3, 'hA3); xa(3, 1);
    step(2);
    push(0, 'h0F, 1);
    xs(0, 'h0F); xa(0, 1);
    wait_drain(120);

    // forced release at MAX_BURST
    do_reset();
    for (int k = 0; k < 16; k++) push(1, 'h80 + k, 0);
    push(1, 'h90, 1);
    push(2, 'h2B, 1);
    for (int k = 0; k < 16; k++) begin
      xs(1, 'h80 + k); xa(1, k == 15);
    end
    xs(2, 'h2B); xa(2, 1);
    xs(1, 'h90); xa(1, 1);
    wait_drain(600);

    // reset while waiting on tx
    do_reset();
    push(1, 'h11, 1);
    xs(1, 'h11);
    step(5);
    post("wait_busy", 0, 1);
    step(1);
    rst = 1'b0;
    #1;
    post("arst_busy", 0, 0);
    post("arst_start", 1, 0);
    post("arst_ack", 3, 0);
    post("arst_gid", 4, 0);
    step(1);
    rst = 1'b1;
    step(12);
    post("stale_done_busy", 0, 0);
    step(1);
    push(2, 'h22, 1); push(3, 'h33, 1);
    xs(2, 'h22); xa(2, 1); xs(3, 'h33); xa(3, 1);
    wait_drain(120);

    // stray tx_done in IDLE and HOLD
    force_done = 1'b1;
    step(1);
    force_done = 1'b0;
    step(2);
    post("idle_done_busy", 0, 0);
    post("idle_done_drain", 5, 0);
    step(1);
    push(3, 'hB1, 0);
    xs(3, 'hB1); xa(3, 0);
    for (int k = 0; k < 40; k++) begin
      if (head[3] == tail[3]) break;
      step(1);
    end
    step(2);
    force_done = 1'b1;
    step(1);
    force_done = 1'b0;
    step(3);
    post("hold_done_busy", 0, 1);
    post("hold_done_start", 1, 0);
    post("hold_done_gid", 4, 3);
    step(1);
    push(3, 'hB2, 1);
    xs(3, 'hB2); xa(3, 1);
    wait_drain(60);

    step(2);
    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end

endmodule
